debouncer_multi: RTL and testbench

//  N_CH-channel pushbutton debouncer with per-channel enable. Each channel emits DPB, SCEN, MCEN and CCEN.

---
 rtl/debouncer_multi.sv | 151 +++++++++++++++
 tb/tb_debouncer_multi.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_multi.sv
// Multi-channel pushbutton debouncer: 2-flop synchroniser, per-channel qualify/hold FSM, DPB/SCEN/MCEN/CCEN.
// Latency: 2 synchroniser cycles plus a registered output stage; no backpressure, every clk edge is consumed.
module debouncer_multi #(
  parameter int N_CH       = 4,
  parameter int T_QUAL     = 8,
  parameter int T_HOLD     = 16,
  parameter int MCEN_BURST = 8,
  parameter bit PB_ACT_LOW = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] pb_in,
  input  logic [N_CH-1:0] ch_en,
  output logic [N_CH-1:0] DPB,
  output logic [N_CH-1:0] SCEN,
  output logic [N_CH-1:0] MCEN,
  output logic [N_CH-1:0] CCEN,
  output logic            any_dpb
);

  localparam int T_MAX = (T_QUAL > T_HOLD) ? T_QUAL : T_HOLD;
  localparam int CW    = $clog2(T_MAX);
  localparam int BW    = (MCEN_BURST > 0) ? $clog2(MCEN_BURST + 1) : 1;

  localparam logic [CW-1:0] QUAL_LAST = CW'(T_QUAL - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(T_HOLD - 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MCEN_BURST);

  typedef enum logic [3:0] {
    S_INI, S_WQ, S_SCEN, S_WH, S_MCEN, S_CCEN_W, S_CONT, S_CCR, S_WFCR
  } state_e;

  // {DPB, SCEN, MCEN, CCEN} for each state
  function automatic logic [3:0] decode(input state_e s);
    logic [3:0] o;
    o = 4'b0000;
    case (s)
      S_SCEN:   o = 4'b1111;
      S_WH:     o = 4'b1000;
      S_MCEN:   o = 4'b1011;
      S_CCEN_W: o = 4'b1001;
      S_CONT:   o = 4'b1011;
      S_CCR:    o = 4'b1000;
      S_WFCR:   o = 4'b1000;
      default:  o = 4'b0000;
    endcase
    return o;
  endfunction

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [N_CH-1:0] dpb_d;
  logic            any_dpb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      any_dpb_q <= 1'b0;
    end else begin
      sync1_q   <= pb_in ^ {N_CH{PB_ACT_LOW}};
      sync2_q   <= sync1_q;
      any_dpb_q <= |dpb_d;
    end
  end

  assign any_dpb = any_dpb_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] burst_q, burst_d, burst_inc;
    logic [3:0]    out_q, out_d;
    logic          pb;

    assign pb        = sync2_q[i];
    assign burst_inc = (MCEN_BURST == 0 || burst_q == BURST_MAX) ? burst_q : burst_q + 1'b1;

    always_comb begin
      state_d = state_q;
      burst_d = burst_q;
      unique case (state_q)
        S_INI:    if (pb) state_d = S_WQ;
        S_WQ: begin
          if (!pb)                    state_d = S_INI;
          else if (cnt_q == QUAL_LAST) state_d = S_SCEN;
        end
        S_SCEN: begin
          state_d = S_WH;
          burst_d = burst_inc;
        end
        S_WH: begin
          if (!pb)                    state_d = S_CCR;
          else if (cnt_q == HOLD_LAST) state_d = S_MCEN;
        end
        S_MCEN: begin
          state_d = S_CCEN_W;
          burst_d = burst_inc;
        end
        S_CCEN_W: begin
          if (!pb) state_d = S_CCR;
          else if (cnt_q == QUAL_LAST)
            state_d = (MCEN_BURST != 0 && burst_q == BURST_MAX) ? S_CONT : S_MCEN;
        end
        S_CONT:   if (!pb) state_d = S_CCR;
        S_CCR: begin
          state_d = S_WFCR;
          burst_d = '0;
        end
        // A re-press while waiting out the release is treated as bounce
        S_WFCR: begin
          if (pb)                     state_d = S_WH;
          else if (cnt_q == QUAL_LAST) state_d = S_INI;
        end
        default:  state_d = S_INI;
      endcase

      if (!ch_en[i]) state_d = S_INI;
      if (state_d == S_INI) burst_d = '0;

      // Every state starts timing from zero; the timer only runs while a state persists
      if (state_d != state_q || state_d == S_INI || state_d == S_CONT)
        cnt_d = '0;
      else
        cnt_d = cnt_q + 1'b1;

      out_d = decode(state_d);
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= S_INI;
        cnt_q   <= '0;
        burst_q <= '0;
        out_q   <= 4'b0000;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        burst_q <= burst_d;
        out_q   <= out_d;
      end
    end

    assign dpb_d[i] = out_d[3];
    assign DPB[i]   = out_q[3];
    assign SCEN[i]  = out_q[2];
    assign MCEN[i]  = out_q[1];
    assign CCEN[i]  = out_q[0];
  end

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi: two instances (burst of 3 and auto-repeat) against a timing-rule reference model.
// Directed press/release/bounce/reset/enable scenarios followed by randomized bursty stimulus.
module tb_debouncer_multi;
  localparam int N_CH   = 2;
  localparam int T_QUAL = 4;
  localparam int T_HOLD = 8;
  localparam int NCFG   = 2;
  localparam int LOGN   = 128;

  logic            clk   = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] pb_in = '0;
  logic [N_CH-1:0] ch_en = '1;

  logic [N_CH-1:0] b_dpb, b_scen, b_mcen, b_ccen;
  logic            b_any;
  logic [N_CH-1:0] r_dpb, r_scen, r_mcen, r_ccen;
  logic            r_any;

  debouncer_multi #(.N_CH(N_CH), .T_QUAL(T_QUAL), .T_HOLD(T_HOLD), .MCEN_BURST(3), .PB_ACT_LOW(1'b0)) u_dut (
    .clk(clk), .reset(reset), .pb_in(pb_in), .ch_en(ch_en),
    .DPB(b_dpb), .SCEN(b_scen), .MCEN(b_mcen), .CCEN(b_ccen), .any_dpb(b_any));

  debouncer_multi #(.N_CH(N_CH), .T_QUAL(T_QUAL), .T_HOLD(T_HOLD), .MCEN_BURST(0), .PB_ACT_LOW(1'b0)) u_rep (
    .clk(clk), .reset(reset), .pb_in(pb_in), .ch_en(ch_en),
    .DPB(r_dpb), .SCEN(r_scen), .MCEN(r_mcen), .CCEN(r_ccen), .any_dpb(r_any));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int edge_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: press qualification by run length, hold phase as a pulse schedule
  int burst_cfg [NCFG] = '{3, 0};
  bit p1 [N_CH];
  bit p2 [N_CH];
  bit m_deb  [NCFG][N_CH];
  bit m_rph  [NCFG][N_CH];
  bit m_cont [NCFG][N_CH];
  bit m_skip [NCFG][N_CH];
  int m_run  [NCFG][N_CH];
  int m_a    [NCFG][N_CH];
  int m_n    [NCFG][N_CH];
  int m_rel  [NCFG][N_CH];
  logic [N_CH-1:0] e_dpb [NCFG];
  logic [N_CH-1:0] e_scen[NCFG];
  logic [N_CH-1:0] e_mcen[NCFG];
  logic [N_CH-1:0] e_ccen[NCFG];
  logic            e_any [NCFG];

  bit lg_scen [LOGN];
  bit lg_dpb  [LOGN];
  bit lg_mcen [LOGN];
  bit lg_rmcen[LOGN];

  task automatic mclear();
    for (int i = 0; i < N_CH; i++) begin
      p1[i] = 1'b0;
      p2[i] = 1'b0;
    end
    for (int c = 0; c < NCFG; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        m_deb[c][i] = 0; m_rph[c][i] = 0; m_cont[c][i] = 0; m_skip[c][i] = 0;
        m_run[c][i] = 0; m_a[c][i] = 0;   m_n[c][i] = 0;    m_rel[c][i] = 0;
      end
      e_dpb[c] = '0; e_scen[c] = '0; e_mcen[c] = '0; e_ccen[c] = '0; e_any[c] = 1'b0;
    end
  endtask

  task automatic mstep(input int c, input int i, input bit pb, input bit en);
    bit pulse, sc, hold;
    int b;
    pulse = 0;
    sc    = 0;
    b     = burst_cfg[c];
    if (!en) begin
      m_deb[c][i] = 0; m_rph[c][i] = 0; m_cont[c][i] = 0; m_run[c][i] = 0;
    end else if (!m_deb[c][i]) begin
      m_run[c][i] = pb ? m_run[c][i] + 1 : 0;
      if (m_run[c][i] == T_QUAL + 1) begin
        sc = 1;
        m_deb[c][i] = 1; m_rph[c][i] = 0; m_cont[c][i] = 0; m_skip[c][i] = 1;
        m_a[c][i] = 0;   m_n[c][i] = 1;   m_run[c][i] = 0;
      end
    end else if (!m_rph[c][i]) begin
      m_a[c][i]++;
      if (!m_skip[c][i] && !pb) begin
        m_rph[c][i] = 1; m_rel[c][i] = 0; m_cont[c][i] = 0;
      end else if (!m_cont[c][i] && m_a[c][i] >= T_HOLD + 1 &&
                   (m_a[c][i] - (T_HOLD + 1)) % (T_QUAL + 1) == 0) begin
        if (m_a[c][i] > T_HOLD + 1 && b != 0 && m_n[c][i] >= b) m_cont[c][i] = 1;
        else begin
          pulse = 1;
          if (m_n[c][i] < b) m_n[c][i]++;
        end
      end
      m_skip[c][i] = pulse;
    end else begin
      m_rel[c][i]++;
      if (m_rel[c][i] >= 2 && pb) begin
        m_rph[c][i] = 0; m_a[c][i] = 1; m_n[c][i] = 0; m_skip[c][i] = 0;
      end else if (m_rel[c][i] >= T_QUAL + 1) begin
        m_deb[c][i] = 0; m_rph[c][i] = 0; m_run[c][i] = 0;
      end
    end
    hold = m_deb[c][i] && !m_rph[c][i];
    e_dpb[c][i]  = m_deb[c][i];
    e_scen[c][i] = sc;
    e_mcen[c][i] = hold && (sc || pulse || m_cont[c][i]);
    e_ccen[c][i] = hold && (sc || m_cont[c][i] || m_a[c][i] >= T_HOLD + 1);
  endtask

  task automatic cmp(input int c, input logic [N_CH-1:0] dpb, input logic [N_CH-1:0] scen,
                     input logic [N_CH-1:0] mcen, input logic [N_CH-1:0] ccen, input logic any);
    chk($sformatf("dpb%0d@%0d", c, edge_n),  dpb,  e_dpb[c]);
    chk($sformatf("scen%0d@%0d", c, edge_n), scen, e_scen[c]);
    chk($sformatf("mcen%0d@%0d", c, edge_n), mcen, e_mcen[c]);
    chk($sformatf("ccen%0d@%0d", c, edge_n), ccen, e_ccen[c]);
    chk($sformatf("any%0d@%0d", c, edge_n),  any,  e_any[c]);
  endtask

  task automatic step();
    bit seen [N_CH];
    @(posedge clk);
    if (reset) begin
      edge_n++;
      for (int i = 0; i < N_CH; i++) begin
        seen[i] = p2[i];
        p2[i]   = p1[i];
        p1[i]   = pb_in[i];
      end
      for (int c = 0; c < NCFG; c++) begin
        for (int i = 0; i < N_CH; i++) mstep(c, i, seen[i], ch_en[i]);
        e_any[c] = |e_dpb[c];
      end
    end else begin
      mclear();
    end
    @(negedge clk);
    cmp(0, b_dpb, b_scen, b_mcen, b_ccen, b_any);
    cmp(1, r_dpb, r_scen, r_mcen, r_ccen, r_any);
    if (reset && edge_n < LOGN) begin
      lg_scen[edge_n]  = b_scen[0];
      lg_dpb[edge_n]   = b_dpb[0];
      lg_mcen[edge_n]  = b_mcen[0];
      lg_rmcen[edge_n] = r_mcen[0];
    end
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b0;
    #1;
    chk("rst_dpb",  {b_dpb, r_dpb},   '0);
    chk("rst_scen", {b_scen, r_scen}, '0);
    chk("rst_mcen", {b_mcen, r_mcen}, '0);
    chk("rst_ccen", {b_ccen, r_ccen}, '0);
    chk("rst_any",  {b_any, r_any},   '0);
    mclear();
    repeat (cycles) step();
    reset  = 1'b1;
    edge_n = 0;
    for (int k = 0; k < LOGN; k++) begin
      lg_scen[k] = 0; lg_dpb[k] = 0; lg_mcen[k] = 0; lg_rmcen[k] = 0;
    end
  endtask

  function automatic int first_at(input bit a [LOGN], input int from, input bit val);
    for (int k = from; k < LOGN; k++) if (a[k] == val) return k;
    return -1;
  endfunction

  function automatic int count_set(input bit a [LOGN], input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (a[k]) n++;
    return n;
  endfunction

  function automatic int longest_run(input bit a [LOGN]);
    int best = 0, cur = 0;
    for (int k = 0; k < LOGN; k++) begin
      cur  = a[k] ? cur + 1 : 0;
      best = (cur > best) ? cur : best;
    end
    return best;
  endfunction

  int hold_left [N_CH];

  initial begin
    mclear();
    apply_reset(3);

    // Short glitch: never qualifies
    pb_in[0] = 1'b1; repeat (3) step();
    pb_in[0] = 1'b0; repeat (12) step();
    chk("glitch_scen", count_set(lg_scen, 1, 15), 0);
    chk("glitch_dpb",  count_set(lg_dpb, 1, 15), 0);

    // Long hold: SCEN, hold pulses, burst then continuous, release
    apply_reset(2);
    pb_in[0] = 1'b1; repeat (60) step();
    pb_in[0] = 1'b0; repeat (12) step();
    chk("hold_scen_edge", first_at(lg_scen, 1, 1), 7);
    chk("hold_scen_once", count_set(lg_scen, 1, 72), 1);
    chk("hold_dpb_edge",  first_at(lg_dpb, 1, 1), 7);
    chk("hold_mcen7",  lg_mcen[7], 1);
    chk("hold_mcen16", lg_mcen[16], 1);
    chk("hold_mcen21", lg_mcen[21], 1);
    chk("hold_mcen_gap", count_set(lg_mcen, 8, 15) + count_set(lg_mcen, 17, 20), 0);
    chk("hold_cont_start", first_at(lg_mcen, 22, 1), 26);
    chk("hold_cont_len",   count_set(lg_mcen, 26, 62), 37);
    chk("hold_cont_end",   lg_mcen[63], 0);
    chk("hold_dpb_fall",   first_at(lg_dpb, 61, 0), 68);
    chk("rep_mcen26", lg_rmcen[26], 1);
    chk("rep_mcen27", lg_rmcen[27], 0);
    chk("rep_pulses", count_set(lg_rmcen, 22, 62), 8);
    chk("rep_no_cont", longest_run(lg_rmcen), 1);

    // Bounce during release: no new SCEN, hold timing restarts
    apply_reset(2);
    pb_in[0] = 1'b1; repeat (20) step();
    pb_in[0] = 1'b0; repeat (2) step();
    pb_in[0] = 1'b1; repeat (20) step();
    pb_in[0] = 1'b0; repeat (12) step();
    chk("bounce_scen_once", count_set(lg_scen, 1, 54), 1);
    chk("bounce_dpb_held",  first_at(lg_dpb, 7, 0), 50);
    chk("bounce_next_mcen", first_at(lg_mcen, 22, 1), 33);

    // Reset during continuous on both channels, then channel disable mid-hold
    apply_reset(2);
    pb_in = 2'b11; repeat (40) step();
    chk("both_cont_mcen", b_mcen, 2'b11);
    chk("both_cont_ccen", b_ccen, 2'b11);
    apply_reset(3);
    repeat (25) step();
    chk("requal_scen_edge", first_at(lg_scen, 1, 1), 7);
    ch_en[1] = 1'b0; step();
    chk("dis_dpb1", b_dpb[1], 0);
    chk("dis_dpb0", b_dpb[0], 1);
    repeat (5) step();
    ch_en[1] = 1'b1; repeat (12) step();
    pb_in = 2'b00; repeat (10) step();

    // Randomized bursty presses with occasional enable toggles and resets
    for (int i = 0; i < N_CH; i++) hold_left[i] = 0;
    repeat (3000) begin
      for (int i = 0; i < N_CH; i++) begin
        if (hold_left[i] == 0) begin
          pb_in[i]     = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 40));
        end else begin
          hold_left[i]--;
        end
      end
      if ($urandom_range(0, 199) == 0) begin
        int k;
        k = int'($urandom_range(0, N_CH - 1));
        ch_en[k] = ~ch_en[k];
      end
      if ($urandom_range(0, 999) == 0) apply_reset(1);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
